// File: rtl/gate_controller.sv
// Parking gate controller: admits one car per open cycle, refuses cars when the lot is full,
// and closes the barrier again if nobody drives through within OPEN_TIMEOUT cycles.
module gate_controller #(
  parameter logic [23:0] OPEN_TIMEOUT = 24'd5000000,
  parameter int          STATE_W      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               car_present,
  input  logic               pass_sensor,
  input  logic               space_avail,
  output logic               barrier_open,
  output logic               entry_pulse,
  output logic               denied,
  output logic               timeout,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OPEN     = 3'd1,
    S_PASSING  = 3'd2,
    S_CLEARING = 3'd3,
    S_DENIED   = 3'd4
  } state_t;

  state_t      r_state;
  logic [23:0] r_wait_cnt;

  state_t      w_next;
  logic        w_entry;
  logic        w_timeout;

  always_comb begin
    w_next    = S_IDLE;
    w_entry   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (car_present && space_avail) w_next = S_OPEN;
        else if (car_present)           w_next = S_DENIED;
        else                            w_next = S_IDLE;
      end
      S_OPEN: begin
        // A car breaking the beam wins over an expiring wait in the same cycle.
        if (pass_sensor) begin
          w_next = S_PASSING;
        end else if (r_wait_cnt == OPEN_TIMEOUT - 24'd1) begin
          w_next    = S_CLEARING;
          w_timeout = 1'b1;
        end else begin
          w_next = S_OPEN;
        end
      end
      S_PASSING: begin
        if (!pass_sensor) begin
          w_next  = S_CLEARING;
          w_entry = 1'b1;
        end else begin
          w_next = S_PASSING;
        end
      end
      S_CLEARING: w_next = car_present ? S_CLEARING : S_IDLE;
      S_DENIED: begin
        if (!car_present)     w_next = S_IDLE;
        else if (space_avail) w_next = S_OPEN;
        else                  w_next = S_DENIED;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they line up with state_o.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 24'd0;
      barrier_open <= 1'b0;
      entry_pulse  <= 1'b0;
      denied       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_state      <= w_next;
      barrier_open <= (w_next == S_OPEN) || (w_next == S_PASSING);
      denied       <= (w_next == S_DENIED);
      entry_pulse  <= w_entry;
      timeout      <= w_timeout;
      if (r_state != S_OPEN)         r_wait_cnt <= 24'd0;
      else if (r_wait_cnt != '1)     r_wait_cnt <= r_wait_cnt + 24'd1;
    end
  end

  assign state_o = STATE_W'(r_state);

endmodule

// File: doc/gate_controller.md
GATE_CONTROLLER -- requirements
Module: gate_controller

Interface
REQ-001 OPEN_TIMEOUT, 24'd5000000, cycles barrier stays open waiting for a car to reach the pass sensor.
REQ-002 STATE_W, 3, width of state_o.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; no other reset source.
REQ-005 car_present  input  1  debounced level: vehicle waiting at the gate loop.
REQ-006 pass_sensor  input  1  debounced level: beam past the barrier is broken.
REQ-007 space_avail  input  1  level from the downstream lot counter: 1 = free space remains.
REQ-008 barrier_open  output  1  registered; 1 = drive barrier up.
REQ-009 entry_pulse  output  1  registered one-cycle pulse per admitted car; feeds the lot counter's entry input.
REQ-010 denied  output  1  registered; 1 = "lot full" lamp while a car is refused.
REQ-011 timeout  output  1  registered one-cycle pulse when an open barrier times out with no car passing.
REQ-012 state_o  output  STATE_W  current FSM state code, for debug and the display.

Function
REQ-013 The FSM SHALL have states IDLE=0, OPEN=1, PASSING=2, CLEARING=3, DENIED=4; codes 5-7 SHALL return to IDLE next cycle.
REQ-014 IDLE: car_present=1 and space_avail=1 -> OPEN; car_present=1 and space_avail=0 -> DENIED; else stay.
REQ-015 OPEN: barrier_open=1; 24-bit wait counter cleared on entry, +1 per cycle.
REQ-016 OPEN: pass_sensor=1 -> PASSING (takes priority over timeout in the same cycle).
REQ-017 OPEN: counter == OPEN_TIMEOUT-1 with pass_sensor=0 -> CLEARING, timeout=1 for one cycle, no entry_pulse.
REQ-018 PASSING: barrier_open=1 held; pass_sensor falling to 0 -> CLEARING with entry_pulse=1 for exactly one cycle.
REQ-019 CLEARING: barrier_open=0; stay while car_present=1; -> IDLE on the first cycle car_present=0. This stops one car from being admitted twice.
REQ-020 DENIED: denied=1, barrier_open=0; space_avail rising to 1 with car_present=1 -> OPEN; car_present=0 -> IDLE.
REQ-021 All outputs SHALL be registered; barrier_open and denied SHALL reflect the state entered, one cycle after the transition condition is sampled.
REQ-022 At most one entry_pulse SHALL occur per IDLE->OPEN cycle; entry_pulse and timeout SHALL never both be 1.
REQ-023 A change in space_avail while in OPEN or PASSING SHALL NOT close the barrier; the car already admitted is completed.
REQ-024 In OPEN, pass_sensor already 1 on entry SHALL move to PASSING on the next cycle.
REQ-025 The wait counter SHALL saturate, not wrap; it is only meaningful in OPEN.

Reset
REQ-026 reset=1 SHALL immediately, without clk, force state IDLE, counter 0, and barrier_open, entry_pulse, denied, timeout = 0, state_o=0.
REQ-027 Reset asserted mid-operation (OPEN/PASSING) SHALL drop barrier_open asynchronously and SHALL NOT emit entry_pulse.
REQ-028 After reset deassertion, the first transition SHALL occur on the following rising edge if its condition holds.

Verification (OPEN_TIMEOUT=8)
REQ-029 Normal admit: space_avail=1, car_present=1 -> OPEN after 1 clk; pass_sensor 1 for 3 clk then 0, car_present 0 -> exactly one entry_pulse, barrier_open 0, state IDLE.
REQ-030 Full lot: space_avail=0, car_present=1 for 10 clk -> denied=1 from cycle 2, barrier_open 0 throughout; space_avail->1 -> OPEN next cycle, denied 0.
REQ-031 Timeout: admit, pass_sensor held 0 -> timeout pulse 8 clk after entering OPEN, barrier_open 0, no entry_pulse; car_present held 1 keeps CLEARING, no reopen.
REQ-032 Race: pass_sensor=1 on the same edge the counter hits 7 -> PASSING, no timeout pulse.
REQ-033 Async reset in PASSING: assert reset between clock edges -> barrier_open 0 before the next edge, no entry_pulse, state_o=0.
REQ-034 Back-to-back cars: two full admit sequences separated by car_present low for 1 clk -> exactly 2 entry_pulses, each 1 cycle wide.
